// File: rtl/mbm_pkg.sv
// Shared types and default widths for the memory block mover.
package mbm_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 16;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Per-word transform selection; code 3 aliases COPY
    typedef enum logic [1:0] {
        OP_COPY   = 2'd0,
        OP_INVERT = 2'd1,
        OP_FILL0  = 2'd2,
        OP_COPY3  = 2'd3
    } op_e;

endpackage

// File: rtl/mbm_pixel_op.sv
// Combinational per-word transform applied between read and write.
module mbm_pixel_op #(
    parameter int unsigned DATA_W = mbm_pkg::DATA_W
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout_c
);
    import mbm_pkg::*;

    // Select the transform; unknown codes fall back to a plain copy
    always_comb begin
        dout_c = din;
        case (op)
            OP_INVERT: dout_c = ~din;
            OP_FILL0:  dout_c = '0;
            default:   dout_c = din;
        endcase
    end

endmodule

// File: rtl/mem_block_mover.sv
// Moves a block of words from src to dst through a single-port memory,
// alternating one read cycle and one write cycle per word.
module mem_block_mover #(
    parameter int unsigned ADDR_W = mbm_pkg::ADDR_W,
    parameter int unsigned DATA_W = mbm_pkg::DATA_W,
    parameter int unsigned LEN_W  = mbm_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  length,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  count
);
    import mbm_pkg::*;

    localparam logic [1:0] IDLE  = 2'(S_IDLE);
    localparam logic [1:0] READ  = 2'(S_READ);
    localparam logic [1:0] WRITE = 2'(S_WRITE);
    localparam logic [1:0] DONE  = 2'(S_DONE);

    logic [1:0]        state_q, state_n;
    logic [ADDR_W-1:0] src_q,   src_n;
    logic [ADDR_W-1:0] dst_q,   dst_n;
    logic [LEN_W-1:0]  len_q,   len_n;
    logic [1:0]        op_q,    op_n;
    logic [LEN_W-1:0]  idx_q,   idx_n;
    logic [DATA_W-1:0] data_q,  data_n;
    logic [LEN_W-1:0]  count_n;
    logic              we_n;
    logic [ADDR_W-1:0] a_n;
    logic [DATA_W-1:0] wd_n;
    logic              busy_n;
    logic              done_n;
    logic [DATA_W-1:0] wd_c;

    // Data register captures the read word at the end of READ
    assign data_n = (state_q == READ) ? mem_rd : data_q;

    // Transform of the word being captured, registered onto mem_wd
    mbm_pixel_op #(
        .DATA_W (DATA_W)
    ) u_pixel_op (
        .op     (op_q),
        .din    (data_n),
        .dout_c (wd_c)
    );

    // Next-state and next-output decode; memory outputs are driven from
    // registers, so each branch sets up what the following state presents
    always_comb begin
        state_n = state_q;
        src_n   = src_q;
        dst_n   = dst_q;
        len_n   = len_q;
        op_n    = op_q;
        idx_n   = idx_q;
        count_n = count;
        we_n    = 1'b0;
        a_n     = '0;
        wd_n    = '0;
        busy_n  = 1'b0;
        done_n  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_n   = src_base;
                    dst_n   = dst_base;
                    len_n   = length;
                    op_n    = op;
                    idx_n   = '0;
                    count_n = '0;
                    busy_n  = 1'b1;
                    if (length != '0) begin
                        state_n = READ;
                        a_n     = src_base;
                    end else begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end
            end
            READ: begin
                state_n = WRITE;
                busy_n  = 1'b1;
                we_n    = 1'b1;
                a_n     = dst_q + ADDR_W'(idx_q);
                wd_n    = wd_c;
            end
            WRITE: begin
                idx_n   = idx_q + LEN_W'(1);
                count_n = count + LEN_W'(1);
                busy_n  = 1'b1;
                if (idx_q == len_q - LEN_W'(1)) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    state_n = READ;
                    a_n     = src_q + ADDR_W'(idx_n);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, operand and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            op_q    <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            count   <= '0;
            mem_we  <= 1'b0;
            mem_a   <= '0;
            mem_wd  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_n;
            src_q   <= src_n;
            dst_q   <= dst_n;
            len_q   <= len_n;
            op_q    <= op_n;
            idx_q   <= idx_n;
            data_q  <= data_n;
            count   <= count_n;
            mem_we  <= we_n;
            mem_a   <= a_n;
            mem_wd  <= wd_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_mem_block_mover.sv
// Testbench for mem_block_mover: table of transfers plus reset and
// busy-start corner sequences, checked against a read/write scoreboard.
module tb_mem_block_mover;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] src_base = '0;
    logic [31:0] dst_base = '0;
    logic [15:0] length = '0;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        busy;
    logic        done;
    logic [15:0] count;

    always #5 clk = ~clk;

    mem_block_mover #(
        .ADDR_W (32),
        .DATA_W (32),
        .LEN_W  (16)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .src_base (src_base),
        .dst_base (dst_base),
        .length   (length),
        .mem_we   (mem_we),
        .mem_a    (mem_a),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    // Preloaded memory contents; unlisted addresses return a pattern of the address
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        case (a)
            32'd4000: return 32'h11111111;
            32'd4001: return 32'h22222222;
            32'd4002: return 32'h33333333;
            32'd4003: return 32'h44444444;
            32'd5000: return 32'h12345678;
            default:  return a ^ 32'hA5A5A5A5;
        endcase
    endfunction

    assign mem_rd = mem_model(mem_a);

    function automatic logic [31:0] xform(input logic [1:0] o, input logic [31:0] d);
        case (o)
            2'd1:    return ~d;
            2'd2:    return 32'h0;
            default: return d;
        endcase
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int unsigned edge_n;
    } wr_t;

    typedef struct {
        logic [31:0] a;
        int unsigned edge_n;
    } rd_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        logic [15:0] exp_count;
        logic [31:0] exp_wd0;
    } vec_t;

    wr_t         wrq[$];
    rd_t         rdq[$];
    int unsigned doneq[$];

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int          wr_seen = 0;
    bit          done_seen = 1'b0;
    logic [31:0] first_wd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: event with no expectation (t=%0t)", name, $time);
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        wr_t w;
        rd_t r;
        if (mem_we) begin
            if (wrq.size() == 0) begin
                flag("unexpected_write");
            end else begin
                w = wrq.pop_front();
                chk("wr_addr", 64'(mem_a), 64'(w.a));
                chk("wr_data", 64'(mem_wd), 64'(w.d));
                chk("wr_edge", 64'(cyc + 1), 64'(w.edge_n));
            end
            if (wr_seen == 0) first_wd = mem_wd;
            wr_seen++;
        end else if (busy && !done) begin
            if (rdq.size() == 0) begin
                flag("unexpected_read");
            end else begin
                r = rdq.pop_front();
                chk("rd_addr", 64'(mem_a), 64'(r.a));
                chk("rd_edge", 64'(cyc), 64'(r.edge_n));
            end
        end
        if (done) begin
            if (doneq.size() == 0) flag("unexpected_done");
            else chk("done_edge", 64'(cyc), 64'(doneq.pop_front()));
            done_seen = 1'b1;
        end
        if (!busy) begin
            chk("idle_addr", 64'(mem_a), 64'h0);
            chk("idle_wd", 64'(mem_wd), 64'h0);
        end
    end

    // Called on a falling edge: queue expectations, pulse start, then scramble operands
    task automatic launch(input logic [1:0] o, input logic [31:0] ps, input logic [31:0] pd,
                          input logic [15:0] l);
        int unsigned k;
        k = cyc + 1;
        for (int n = 0; n < int'(l); n++) begin
            rdq.push_back('{a: ps + 32'(n), edge_n: k + 32'(2 * n)});
            wrq.push_back('{a: pd + 32'(n), d: xform(o, mem_model(ps + 32'(n))),
                            edge_n: k + 32'(2 * n + 2)});
        end
        doneq.push_back(k + 2 * 32'(l));
        done_seen = 1'b0;
        wr_seen = 0;
        first_wd = 32'hDEADBEEF;
        op = o;
        src_base = ps;
        dst_base = pd;
        length = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom);
        src_base = $urandom;
        dst_base = $urandom;
        length = 16'($urandom);
    endtask

    task automatic finish_xfer(input string tag, input logic [15:0] exp_cnt, input int bound);
        for (int i = 0; i < bound && !done_seen; i++) @(negedge clk);
        chk({tag, "_done_seen"}, 64'(done_seen), 64'h1);
        @(negedge clk);
        chk({tag, "_count"}, 64'(count), 64'(exp_cnt));
        chk({tag, "_busy_after"}, 64'(busy), 64'h0);
        chk({tag, "_wr_left"}, 64'(wrq.size()), 64'h0);
        chk({tag, "_rd_left"}, 64'(rdq.size()), 64'h0);
        chk({tag, "_done_left"}, 64'(doneq.size()), 64'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_done"}, 64'(done), 64'h0);
        chk({tag, "_we"}, 64'(mem_we), 64'h0);
        chk({tag, "_a"}, 64'(mem_a), 64'h0);
        chk({tag, "_wd"}, 64'(mem_wd), 64'h0);
        chk({tag, "_count"}, 64'(count), 64'h0);
    endtask

    task automatic flush_queues();
        wrq.delete();
        rdq.delete();
        doneq.delete();
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{op: 2'd0, src: 32'd4000, dst: 32'd40000, len: 16'd4,
                    exp_count: 16'd4, exp_wd0: 32'h11111111};
        vecs[1] = '{op: 2'd1, src: 32'd5000, dst: 32'd6000, len: 16'd1,
                    exp_count: 16'd1, exp_wd0: 32'hEDCBA987};
        vecs[2] = '{op: 2'd2, src: 32'd5000, dst: 32'd6100, len: 16'd1,
                    exp_count: 16'd1, exp_wd0: 32'h00000000};
        vecs[3] = '{op: 2'd0, src: 32'd4000, dst: 32'd7700, len: 16'd0,
                    exp_count: 16'd0, exp_wd0: 32'h0};
        vecs[4] = '{op: 2'd3, src: 32'd4001, dst: 32'd7000, len: 16'd2,
                    exp_count: 16'd2, exp_wd0: 32'h22222222};
        vecs[5] = '{op: 2'd0, src: 32'hFFFFFFFF, dst: 32'hFFFFFFFF, len: 16'd2,
                    exp_count: 16'd2, exp_wd0: 32'h5A5A5A5A};

        // Power-on reset
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven transfers
        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].len);
            finish_xfer($sformatf("vec%0d", i), vecs[i].exp_count, 2 * int'(vecs[i].len) + 8);
            chk($sformatf("vec%0d_words", i), 64'(wr_seen), 64'(vecs[i].exp_count));
            if (vecs[i].len != 0) chk($sformatf("vec%0d_wd0", i), 64'(first_wd), 64'(vecs[i].exp_wd0));
        end

        // Start pulses while busy must not disturb the running transfer
        launch(2'd0, 32'd4000, 32'd40000, 16'd4);
        @(negedge clk);
        op = 2'd1;
        src_base = 32'd5000;
        dst_base = 32'd9000;
        length = 16'd1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        finish_xfer("busy_start", 16'd4, 16);
        chk("busy_start_words", 64'(wr_seen), 64'd4);

        // Reset asserted during the second write
        launch(2'd0, 32'd4000, 32'd40000, 16'd4);
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_we", 64'(mem_we), 64'h1);
        rst_n = 1'b0;
        #1 check_reset_outputs("mid_wr_rst");
        chk("mid_wr_rst_words", 64'(wr_seen), 64'd1);
        flush_queues();
        @(negedge clk);
        chk("mid_wr_rst_idle", 64'(busy), 64'h0);

        // First edge after release accepts a start
        rst_n = 1'b1;
        launch(2'd1, 32'd5000, 32'd6000, 16'd1);
        finish_xfer("post_rst", 16'd1, 10);
        chk("post_rst_wd0", 64'(first_wd), 64'hEDCBA987);

        // Resets at random points of longer transfers
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            launch(2'd1, 32'd3998, 32'd8000, 16'd8);
            repeat ($urandom_range(1, 14)) @(posedge clk);
            #($urandom_range(1, 4));
            rst_n = 1'b0;
            #1 check_reset_outputs($sformatf("rand_rst%0d", j));
            flush_queues();
            @(negedge clk);
            rst_n = 1'b1;
        end

        // One more clean transfer after the random resets
        @(negedge clk);
        launch(2'd0, 32'd4002, 32'd123, 16'd2);
        finish_xfer("final", 16'd2, 12);
        chk("final_wd0", 64'(first_wd), 64'h33333333);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_block_mover.md
MEM_BLOCK_MOVER -- requirements
Module: mem_block_mover

Interface
REQ-001 Parameter ADDR_W, default 32: word-address width of the memory port.
REQ-002 Parameter DATA_W, default 32: data width of the memory port.
REQ-003 Parameter LEN_W, default 16: width of the transfer length and progress count.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 start  in  1  request pulse; sampled only in IDLE.
REQ-007 op  in  2  transform: 0 COPY, 1 INVERT (bitwise NOT), 2 FILL0 (write zero), 3 treated as COPY.
REQ-008 src_base  in  ADDR_W  first source word address; latched on accepted start.
REQ-009 dst_base  in  ADDR_W  first destination word address; latched on accepted start.
REQ-010 length  in  LEN_W  number of words to move; latched on accepted start.
REQ-011 mem_we  out  1  write enable to the segmented memory.
REQ-012 mem_a  out  ADDR_W  word address to the segmented memory.
REQ-013 mem_wd  out  DATA_W  write data to the segmented memory.
REQ-014 mem_rd  in  DATA_W  read data from the memory; combinational in mem_a, valid in the same cycle.
REQ-015 busy  out  1  high while a transfer is in progress, i.e. in READ, WRITE or DONE.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 count  out  LEN_W  number of words written in the current or last transfer.

Function
REQ-018 The FSM SHALL have the states IDLE, READ, WRITE and DONE.
REQ-019 IDLE: start=1 with length>0 SHALL latch the operands, clear idx and count, and go to READ; start=1 with length=0 SHALL go to DONE.
REQ-020 READ SHALL drive mem_a=src+idx and mem_we=0, capture mem_rd into a data register at the edge, and go to WRITE.
REQ-021 WRITE SHALL drive mem_a=dst+idx, mem_we=1 and mem_wd=op(data), and increment idx and count at the edge.
REQ-022 From WRITE, the FSM SHALL go to DONE if idx==length-1, else to READ.
REQ-023 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-024 Latency: with start accepted at edge k, the n-th write (n=1..L) SHALL commit at edge k+2n, and done SHALL be high in the cycle following edge k+2L.
REQ-025 For length=0, done SHALL be high in the cycle following edge k, and mem_we SHALL never assert.
REQ-026 Address sums SHALL wrap modulo 2^ADDR_W, and no overflow indication SHALL be produced.
REQ-027 start while busy SHALL be ignored, and the latched operands SHALL be unaffected.
REQ-028 Changes to the operand inputs after acceptance SHALL have no effect on the transfer.
REQ-029 mem_we SHALL be asserted only in WRITE.
REQ-030 mem_a and mem_wd SHALL be 0 in IDLE.
REQ-031 count SHALL hold its final value after done until the next accepted start.

Reset
REQ-032 Asserting rst_n low SHALL immediately force IDLE and clear every output, idx and the data register to 0, including mid-transfer.
REQ-033 After rst_n deasserts, the first rising edge SHALL be able to accept a start.

Structure
REQ-034 Package mbm_pkg SHALL hold the state enum, the op enum, and the default widths ADDR_W, DATA_W and LEN_W.
REQ-035 Sub-module mbm_pixel_op SHALL implement the combinational op transform; all sequencing SHALL remain in mem_block_mover.

Verification
REQ-036 Reset: rst_n=0 at random times -> busy, done, mem_we, mem_a, mem_wd and count all 0 asynchronously.
REQ-037 COPY: src 4000, dst 40000, length 4, memory model preloaded with 0x11111111..0x44444444 -> writes to 40000..40003 at edges k+2, k+4, k+6, k+8; done one cycle; count=4.
REQ-038 INVERT: length 1, source word 0x12345678 -> mem_wd=0xEDCBA987 at dst; FILL0 -> mem_wd=0x00000000.
REQ-039 length=0: start -> done pulse after one edge, mem_we never high, count=0.
REQ-040 start pulsed during busy -> ignored, original transfer completes unchanged; rst_n low during the second WRITE -> mem_we drops immediately, only 1 word written, FSM in IDLE.
REQ-041 Wrap: src 0xFFFFFFFF, length 2 -> reads from 0xFFFFFFFF then 0x00000000.
